// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed hex driver for a bank of common-anode 7-segment digits.
// A load strobe captures a packed nibble word plus per-digit decimal-point,
// blank and blink masks and a leading-zero-suppression enable into shadow
// registers. The scanner holds each digit active for REFRESH_DIV cycles,
// walks digit 0 .. DIGITS-1 and repeats. Every BLINK_FRAMES complete frames
// the blink phase toggles; digits with their blink bit set go dark while the
// phase is 1.
//
// Ports:
//   clk         in   1          system clock, rising edge
//   rst         in   1          synchronous active-high reset
//   load        in   1          capture strobe for data/dp_in/blank_in/blink_in/lz_en
//   data        in   4*DIGITS   packed nibbles, nibble i drives digit i (digit 0 = LS)
//   dp_in       in   DIGITS     1 = decimal point on for digit i
//   blank_in    in   DIGITS     1 = digit i forced dark
//   blink_in    in   DIGITS     1 = digit i dark during blink phase 1
//   lz_en       in   1          leading-zero suppression enable
//   seg         out  7          segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          out  1          decimal point, active-low, registered
//   an          out  DIGITS     one-hot digit select, polarity per ACTIVE_LOW_AN
//   frame_done  out  1          one-cycle pulse per completed scan frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLINK_FRAMES  = 64,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W  = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int TICK_W = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [DIGITS-1:0] AN_IDLE = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    // Shadow registers
    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp_mask;
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   r_blink;
    logic                r_lz;

    // Scan state
    logic [TICK_W-1:0]   r_tick;
    logic [IDX_W-1:0]    r_idx;
    logic [FRM_W-1:0]    r_frame_cnt;
    logic                r_blink_phase;

    // Output registers
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_tick_wrap;
    logic                w_frame_wrap;
    logic                w_blink_wrap;
    logic [3:0]          w_nibble;
    logic                w_dp_bit;
    logic                w_blank_bit;
    logic                w_blink_bit;
    logic                w_zero_above_bit;
    logic [DIGITS-1:0]   w_zero_above;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_dark;
    logic [6:0]          w_seg_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick_wrap  = (r_tick == TICK_LAST);
    assign w_frame_wrap = w_tick_wrap && (r_idx == IDX_LAST);
    assign w_blink_wrap = w_frame_wrap && (r_frame_cnt == FRM_LAST);

    // w_zero_above[i] = nibble i and every more significant nibble are zero.
    always_comb begin
        logic acc;
        acc          = 1'b1;
        w_zero_above = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc             = acc & (r_data[4*i +: 4] == 4'h0);
            w_zero_above[i] = acc;
        end
    end

    // Per-digit selection by the current scan index.
    always_comb begin
        w_nibble         = 4'h0;
        w_dp_bit         = 1'b0;
        w_blank_bit      = 1'b0;
        w_blink_bit      = 1'b0;
        w_zero_above_bit = 1'b0;
        w_onehot         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble         = r_data[4*i +: 4];
                w_dp_bit         = r_dp_mask[i];
                w_blank_bit      = r_blank[i];
                w_blink_bit      = r_blink[i];
                w_zero_above_bit = w_zero_above[i];
                w_onehot[i]      = 1'b1;
            end
        end
    end

    // Digit 0 is excluded from zero suppression so a zero value still shows "0".
    assign w_dark = w_blank_bit
                  | (w_blink_bit & r_blink_phase)
                  | (r_lz & w_zero_above_bit & (r_idx != '0));

    assign w_seg_lit = hex_to_seg(w_nibble);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data        <= '0;
            r_dp_mask     <= '0;
            r_blank       <= '0;
            r_blink       <= '0;
            r_lz          <= 1'b0;
            r_tick        <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_an          <= AN_IDLE;
            r_frame_done  <= 1'b0;
        end else begin
            if (load) begin
                r_data    <= data;
                r_dp_mask <= dp_in;
                r_blank   <= blank_in;
                r_blink   <= blink_in;
                r_lz      <= lz_en;
            end

            if (w_tick_wrap) begin
                r_tick <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            if (w_frame_wrap) begin
                r_frame_cnt <= (r_frame_cnt == FRM_LAST) ? '0 : r_frame_cnt + 1'b1;
            end
            if (w_blink_wrap) begin
                r_blink_phase <= ~r_blink_phase;
            end

            // Outputs reflect the index and shadows as they stood before this edge.
            r_seg        <= w_dark ? 7'b1111111 : w_seg_lit;
            r_dp         <= w_dark ? 1'b1 : ~w_dp_bit;
            r_an         <= (ACTIVE_LOW_AN != 0) ? ~w_onehot : w_onehot;
            r_frame_done <= w_frame_wrap;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int R  = 4;
    localparam int BF = 2;

    // ---------------- clock / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(D), .REFRESH_DIV(R), .BLINK_FRAMES(BF), .ACTIVE_LOW_AN(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // k = number of active edges since reset release. The output after edge k
    // shows digit ((k-1)/R)%D, with blink phase from the count of completed
    // blink periods before that edge.
    logic [6:0]  seg_tab [16];
    int          k;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic        m_lz;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    task automatic model_edge();
        int   idx;
        int   phase;
        logic hz;
        logic dark;
        if (rst) begin
            k = 0;
            m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            k++;
            idx   = ((k - 1) / R) % D;
            phase = ((k - 1) / (R * D * BF)) % 2;
            hz = 1'b1;
            for (int j = idx; j < D; j++)
                if (m_data[4*j +: 4] != 4'h0) hz = 1'b0;
            dark  = m_blank[idx] | (m_blink[idx] && phase == 1) | (m_lz && hz && idx != 0);
            e_seg = dark ? 7'h7F : seg_tab[m_data[4*idx +: 4]];
            e_dp  = dark ? 1'b1 : ~m_dp[idx];
            e_an  = ~(4'b0001 << idx);
            e_fd  = (k % (R * D) == 0);
            if (load) begin
                m_data = data; m_dp = dp_in; m_blank = blank_in;
                m_blink = blink_in; m_lz = lz_en;
            end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", name, $time, k, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_seg", {25'd0, seg}, {25'd0, e_seg});
        check("model_dp",  {31'd0, dp},  {31'd0, e_dp});
        check("model_an",  {28'd0, an},  {28'd0, e_an});
        check("model_fd",  {31'd0, frame_done}, {31'd0, e_fd});
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpm,
                           input logic [3:0] blk, input logic [3:0] bli, input logic lz);
        data = d; dp_in = dpm; blank_in = blk; blink_in = bli; lz_en = lz;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0]     data;
        logic            lz;
        logic [3:0]      dp_m;
        logic [3:0]      blank_m;
        logic [3:0][6:0] exp_seg;  // {digit3, digit2, digit1, digit0}
        logic [3:0]      exp_dp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0] = '{16'h12AF, 1'b0, 4'b0000, 4'b0000,
                    {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
        vecs[1] = '{16'h0050, 1'b1, 4'b0000, 4'b0000,
                    {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
        vecs[2] = '{16'h0000, 1'b1, 4'b0000, 4'b0000,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'h8888, 1'b0, 4'b0100, 4'b1000,
                    {7'b1111111, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b1011};
        vecs[4] = '{16'h0305, 1'b1, 4'b0000, 4'b0000,
                    {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}, 4'b1111};

        // ---- reset with load asserted ----
        rst = 1'b1; load = 1'b1; data = 16'hFFFF;
        dp_in = 4'hF; blank_in = 4'h0; blink_in = 4'h0; lz_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("rst_seg", {25'd0, seg}, 32'h7F);
            check("rst_dp",  {31'd0, dp}, 32'd1);
            check("rst_an",  {28'd0, an}, 32'hF);
            check("rst_fd",  {31'd0, frame_done}, 32'd0);
        end
        rst = 1'b0; load = 1'b0;
        cycle();
        check("rst_shadow_seg", {25'd0, seg}, 32'h40);
        check("rst_release_an", {28'd0, an}, 32'hE);

        // ---- table-driven scans ----
        for (int v = 0; v < 5; v++) begin
            do_reset();
            do_load(vecs[v].data, vecs[v].dp_m, vecs[v].blank_m, 4'h0, vecs[v].lz);
            for (int e = 2; e <= 16; e++) begin
                cycle();
                if (e % 4 == 0) begin
                    check("tab_seg", {25'd0, seg}, {25'd0, vecs[v].exp_seg[e/4-1]});
                    check("tab_dp",  {31'd0, dp},  {31'd0, vecs[v].exp_dp[e/4-1]});
                    check("tab_an",  {28'd0, an},  {28'd0, ~(4'b0001 << (e/4-1))});
                end
                if (e == 15) check("tab_fd_low", {31'd0, frame_done}, 32'd0);
                if (e == 16) check("tab_fd_high", {31'd0, frame_done}, 32'd1);
            end
        end

        // ---- blink on digit 0 over five frames ----
        do_reset();
        do_load(16'h0008, 4'h0, 4'h0, 4'b0001, 1'b0);
        for (int e = 2; e <= 68; e++) begin
            cycle();
            if ((e - 1) % 16 == 3) begin
                if (((e - 1) / 16) == 2 || ((e - 1) / 16) == 3)
                    check("blink_dark", {25'd0, seg}, 32'h7F);
                else
                    check("blink_lit", {25'd0, seg}, 32'h00);
            end
        end

        // ---- reset mid-frame ----
        do_reset();
        do_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int e = 2; e <= 9; e++) cycle();
        check("mid_an_before", {28'd0, an}, 32'hB);
        rst = 1'b1;
        cycle();
        check("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check("mid_rst_an",  {28'd0, an}, 32'hF);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            cycle();
            check("mid_hold_an", {28'd0, an}, 32'hE);
        end
        cycle();
        check("mid_next_an", {28'd0, an}, 32'hD);

        // ---- load on a tick edge, then load latency inside a digit ----
        cycle(); cycle();                               // k = 7
        do_load(16'h0F00, 4'h0, 4'h0, 4'h0, 1'b0);      // k = 8, tick edge
        check("tick_load_old", {25'd0, seg}, 32'h40);
        do_load(16'h0300, 4'h0, 4'h0, 4'h0, 1'b0);      // k = 9
        check("tick_load_new", {25'd0, seg}, 32'h0E);
        cycle();                                        // k = 10
        check("load_latency", {25'd0, seg}, 32'h30);

        // ---- randomized stimulus against the model ----
        do_reset();
        for (int c = 0; c < 900; c++) begin
            logic [15:0] d;
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 3) == 0);
            for (int n = 0; n < 4; n++)
                d[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            data     = d;
            dp_in    = 4'($urandom_range(0, 15));
            blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            blink_in = 4'($urandom_range(0, 15));
            lz_en    = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed hex display driver for a bank of common-anode 7-segment digits.
- Latches a packed nibble word plus per-digit decimal-point, blank and blink masks on a load strobe.
- Scans the digits at a programmable refresh rate, with leading-zero suppression and blinking.
- Sits between the PS/2 / datapath logic and the board display pins; replaces per-digit static decoders.

Parameters:
- DIGITS, 4: number of digits scanned; must be >= 1.
- REFRESH_DIV, 50000: clock cycles each digit is held active; must be >= 1 (1 = advance every cycle).
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be >= 1.
- ACTIVE_LOW_AN, 1: 1 = anode outputs active-low; 0 = active-high.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture strobe for data/dp_in/blank_in/blink_in/lz_en.
- data  in  4*DIGITS  packed nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp_in  in  DIGITS  1 = decimal point on for digit i.
- blank_in  in  DIGITS  1 = digit i forced dark.
- blink_in  in  DIGITS  1 = digit i dark during blink phase 1.
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  DIGITS  one-hot digit select; polarity set by ACTIVE_LOW_AN; registered.
- frame_done  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Shadow registers:
  - At the edge where load=1, capture data, dp_in, blank_in, blink_in and lz_en.
  - Inputs are ignored when load=0.
  - New values drive outputs from the following edge (1-cycle latency load->seg/an).
- Prescaler:
  - tick_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index idx advances modulo DIGITS (DIGITS-1 -> 0).
- Frame and blink:
  - On the edge where idx wraps to 0, frame_done=1 for exactly one cycle.
  - Frame length = DIGITS*REFRESH_DIV cycles.
  - frame_cnt counts frames 0..BLINK_FRAMES-1; on wrap, blink_phase toggles.
- Segment table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Digit dark condition: blank bit set, OR (blink bit set AND blink_phase=1), OR (lz_en AND nibble and all higher nibbles are 0 AND idx != 0).
  - Digit 0 is never zero-suppressed.
- Dark digit: seg=1111111, dp=1; an still selects the digit.
- Lit digit: seg from table; dp = ~dp bit.
- an: one-hot of idx, inverted when ACTIVE_LOW_AN=1.
- Output registers update every cycle from the current idx and shadow values.
- Reset:
  - seg=1111111, dp=1, an all inactive, frame_done=0.
  - idx=0, tick_cnt=0, frame_cnt=0, blink_phase=0, all shadows=0.
  - Reset mid-scan aborts immediately.
  - After release, digit 0 is held for a full REFRESH_DIV count.
- Simultaneous events:
  - load on the same edge as a tick: both take effect; the next digit shows the new data.
  - rst overrides load.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW_AN=1):
- Reset:
  - Stimulus: rst=1 for 3 cycles with load=1, data=16'hFFFF.
  - Response: seg=1111111, dp=1, an=1111, frame_done=0 throughout; shadows stay 0.
- Scan order:
  - Stimulus: load data=16'h12AF, then run.
  - Response: an steps 1110,1101,1011,0111, each for 4 cycles; seg = 0001110, 0001000, 0100100, 1111001 respectively.
  - Response: frame_done pulses every 16 cycles.
- Leading-zero suppression:
  - Stimulus: lz_en=1, data=16'h0050.
  - Response: digits 3 and 2 give seg=1111111; digit 1 gives 0010010; digit 0 gives 1000000.
  - Stimulus: data=16'h0000.
  - Response: only digit 0 is lit (1000000).
- Blink:
  - Stimulus: blink_in=0001, data=16'h0008.
  - Response: digit 0 shows 0000000 in frames 0-1, is dark (1111111) in frames 2-3, then repeats.
- Decimal point and blank:
  - Stimulus: dp_in=0100, blank_in=1000.
  - Response: dp=0 only while an=1011; while an=0111, seg=1111111 and dp=1.
- Reset mid-frame and load latency:
  - Stimulus: assert rst while an=1011.
  - Response: next edge gives reset values; after release, an=1110 for 4 cycles.
  - Stimulus: pulse load with new data at edge t.
  - Response: seg reflects the new data at edge t+1.
